// File: rtl/oppm_packet_receiver.sv
// ----------------------------------------------------------------------------
// oppm_packet_receiver
// Receive side of an OPPM link. The raw pulse line is synchronised to clk,
// rising edges lock the symbol-frame timing on an all-zero preamble, and the
// following data symbols are demodulated MSB-first into one packet that is
// offered to the consumer on a level-valid / read handshake.
//
// Ports
//   clk    in            clock
//   rst_n  in            asynchronous reset, active low
//   pulse  in            raw OPPM pulse line, asynchronous to clk
//   data   out [N_PKT]   last received packet
//   avail  out           data holds an unread packet
//   read   in            consumer takes data
//   err    out           one-cycle strobe: packet dropped, a data frame had no pulse
//   ovf    out           one-cycle strobe: a completed packet overwrote an unread one
// ----------------------------------------------------------------------------
module oppm_packet_receiver #(
    parameter int PULSE_CT = 2,
    parameter int N_MOD    = 2,
    parameter int L        = 8,
    parameter int N_PKT    = 8,
    parameter int PRE_CT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    output logic [N_PKT-1:0] data,
    output logic             avail,
    input  logic             read,
    output logic             err,
    output logic             ovf
);

    localparam int NSLOT = 2 ** N_MOD;
    localparam int DP_CT = (N_PKT + N_MOD - 1) / N_MOD;
    localparam int SH_W  = DP_CT * N_MOD;
    localparam int TW    = (L > 2) ? $clog2(L) : 1;
    localparam int PW    = $clog2(PRE_CT + 1);
    localparam int SCW   = $clog2(DP_CT + 1);

    // Parameter sanity, rejected at elaboration.
    if (PULSE_CT < 1 || PULSE_CT >= L) begin : g_bad_pulse_ct
        $error("oppm_packet_receiver: PULSE_CT must satisfy 1 <= PULSE_CT < L");
    end
    if (L < 2) begin : g_bad_l
        $error("oppm_packet_receiver: L must be >= 2");
    end
    if (PRE_CT < 1) begin : g_bad_pre_ct
        $error("oppm_packet_receiver: PRE_CT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREAM = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            state_r;
    logic              sync1_r, sync2_r, sync3_r;
    logic [TW-1:0]     tick_r;
    logic [N_MOD-1:0]  slot_r;
    logic [PW-1:0]     pre_cnt_r;
    logic [SCW-1:0]    sym_cnt_r;
    logic              got_r;
    logic [SH_W-1:0]   shreg_r;

    logic              is_edge_s;
    logic              at_zero_s;
    logic              at_end_s;
    logic              capture_s;
    logic              got_eff_s;
    logic [SH_W-1:0]   shreg_next_s;
    logic [TW-1:0]     tick_nx_s;
    logic [N_MOD-1:0]  slot_nx_s;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= pulse;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Frame position decode, counter increment and symbol capture path.
    always_comb begin
        is_edge_s = sync2_r & ~sync3_r;
        at_zero_s = (slot_r == {N_MOD{1'b0}}) && (tick_r == {TW{1'b0}});
        at_end_s  = (slot_r == N_MOD'(NSLOT - 1)) && (tick_r == TW'(L - 1));
        if (tick_r == TW'(L - 1)) begin
            tick_nx_s = {TW{1'b0}};
            slot_nx_s = slot_r + N_MOD'(1);
        end else begin
            tick_nx_s = tick_r + TW'(1);
            slot_nx_s = slot_r;
        end
        // Only the first edge of a data frame carries the symbol.
        capture_s = (state_r == DATA) && is_edge_s && !got_r;
        got_eff_s = got_r | capture_s;
        if (capture_s) begin
            shreg_next_s = (shreg_r << N_MOD) | SH_W'(slot_r);
        end else begin
            shreg_next_s = shreg_r;
        end
    end

    // Receiver FSM with frame counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tick_r    <= {TW{1'b0}};
            slot_r    <= {N_MOD{1'b0}};
            pre_cnt_r <= {PW{1'b0}};
            sym_cnt_r <= {SCW{1'b0}};
            got_r     <= 1'b0;
            shreg_r   <= {SH_W{1'b0}};
            data      <= {N_PKT{1'b0}};
            avail     <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            err <= 1'b0;
            ovf <= 1'b0;
            // A read clears avail; a commit in the same cycle overrides below.
            if (avail && read) begin
                avail <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (is_edge_s) begin
                        // Anchor: this cycle is t=0, so next cycle is tick 1.
                        tick_r    <= TW'(1);
                        slot_r    <= {N_MOD{1'b0}};
                        pre_cnt_r <= PW'(1);
                        state_r   <= PREAM;
                    end
                end
                PREAM: begin
                    if (is_edge_s && !at_zero_s) begin
                        // Off-grid edge: re-anchor on it.
                        tick_r    <= TW'(1);
                        slot_r    <= {N_MOD{1'b0}};
                        pre_cnt_r <= PW'(1);
                    end else begin
                        tick_r <= tick_nx_s;
                        slot_r <= slot_nx_s;
                        if (is_edge_s) begin
                            if (pre_cnt_r != PW'(PRE_CT)) begin
                                pre_cnt_r <= pre_cnt_r + PW'(1);
                            end
                        end else if (at_zero_s) begin
                            state_r <= IDLE;
                        end else if (at_end_s && (pre_cnt_r == PW'(PRE_CT))) begin
                            state_r   <= DATA;
                            sym_cnt_r <= {SCW{1'b0}};
                            got_r     <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    tick_r <= tick_nx_s;
                    slot_r <= slot_nx_s;
                    if (capture_s) begin
                        shreg_r <= shreg_next_s;
                        got_r   <= 1'b1;
                    end
                    if (at_end_s) begin
                        got_r <= 1'b0;
                        if (!got_eff_s) begin
                            err     <= 1'b1;
                            shreg_r <= {SH_W{1'b0}};
                            state_r <= IDLE;
                        end else if (sym_cnt_r == SCW'(DP_CT - 1)) begin
                            // Pad bits above N_PKT fall off here.
                            data    <= shreg_next_s[N_PKT-1:0];
                            avail   <= 1'b1;
                            ovf     <= avail & ~read;
                            shreg_r <= {SH_W{1'b0}};
                            state_r <= IDLE;
                        end else begin
                            sym_cnt_r <= sym_cnt_r + SCW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oppm_packet_receiver.sv
// ----------------------------------------------------------------------------
// tb_oppm_packet_receiver
// Directed bench for oppm_packet_receiver. Two instances: the default 8-bit
// configuration and a 7-bit packet variant with one pad bit. Stimulus pushes
// expected packets into per-instance queues; monitors pop and compare when
// the DUT presents a new packet.
// ----------------------------------------------------------------------------
module tb_oppm_packet_receiver;

    localparam int SYM = 32;
    localparam int PW  = 2;

    logic       clk = 1'b0;
    logic       rst_n, pulse, read;
    logic [7:0] data;
    logic       avail, err, ovf;
    logic       rst2_n, pulse2, read2;
    logic [6:0] data2;
    logic       avail2, err2, ovf2;

    always #5 clk = ~clk;

    oppm_packet_receiver #(.PULSE_CT(2), .N_MOD(2), .L(8), .N_PKT(8), .PRE_CT(4)) dut (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .data(data),
        .avail(avail), .read(read), .err(err), .ovf(ovf)
    );

    oppm_packet_receiver #(.PULSE_CT(2), .N_MOD(2), .L(8), .N_PKT(7), .PRE_CT(4)) dut7 (
        .clk(clk), .rst_n(rst2_n), .pulse(pulse2), .data(data2),
        .avail(avail2), .read(read2), .err(err2), .ovf(ovf2)
    );

    typedef struct {
        int d;
        int o;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   err_seen = 0, ovf_seen = 0, err2_seen = 0, ovf2_seen = 0;
    int   frames[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pkt(input int which, input int d, input int o);
        exp_t e;
        e.d = d;
        e.o = o;
        if (which == 0) exp_q.push_back(e);
        else exp2_q.push_back(e);
    endtask

    // One frame per entry of frames[]; entry is the pulse offset, -1 = no pulse.
    task automatic send(input int which);
        foreach (frames[f]) begin
            for (int t = 0; t < SYM; t++) begin
                logic lvl;
                @(posedge clk);
                #1;
                lvl = (frames[f] >= 0) && (t >= frames[f]) && (t < frames[f] + PW);
                if (which == 0) pulse = lvl;
                else pulse2 = lvl;
            end
        end
    endtask

    task automatic do_read();
        @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
    endtask

    // Monitor, default instance: a new packet is avail rising or data changing.
    initial begin
        logic       prev_av;
        logic [7:0] prev_d;
        exp_t       e;
        prev_av = 1'b0;
        prev_d  = 8'h00;
        forever begin
            @(negedge clk);
            if (avail && (!prev_av || data != prev_d)) begin
                chk("commit_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("commit_data", int'(data), e.d);
                    chk("commit_ovf", int'(ovf), e.o);
                end
            end
            if (err) err_seen++;
            if (ovf) ovf_seen++;
            prev_av = avail;
            prev_d  = data;
        end
    end

    // Monitor, 7-bit instance.
    initial begin
        logic       prev_av;
        logic [6:0] prev_d;
        exp_t       e;
        prev_av = 1'b0;
        prev_d  = 7'h00;
        forever begin
            @(negedge clk);
            if (avail2 && (!prev_av || data2 != prev_d)) begin
                chk("commit7_expected", (exp2_q.size() > 0) ? 1 : 0, 1);
                if (exp2_q.size() > 0) begin
                    e = exp2_q.pop_front();
                    chk("commit7_data", int'(data2), e.d);
                    chk("commit7_ovf", int'(ovf2), e.o);
                end
            end
            if (err2) err2_seen++;
            if (ovf2) ovf2_seen++;
            prev_av = avail2;
            prev_d  = data2;
        end
    end

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        pulse  = 1'b1;
        pulse2 = 1'b1;
        read   = 1'b0;
        read2  = 1'b0;

        // 1: reset with pulse high
        idle(3);
        chk("reset_data", int'(data), 0);
        chk("reset_avail", int'(avail), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset7_data", int'(data2), 0);
        chk("reset7_avail", int'(avail2), 0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        idle(4);
        pulse  = 1'b0;
        pulse2 = 1'b0;
        idle(80);
        chk("post_reset_avail", int'(avail), 0);
        chk("post_reset_err_count", err_seen, 0);

        // 2: 0xB4 = symbols 2,3,1,0; check commit latency and hold/read
        frames = '{0, 0, 0, 0, 16, 24, 8, 0};
        expect_pkt(0, 8'hB4, 0);
        send(0);
        idle(2);
        chk("commit_not_early", int'(avail), 0);
        idle(1);
        chk("commit_latency", int'(avail), 1);
        idle(50);
        chk("hold_data", int'(data), 8'hB4);
        chk("hold_avail", int'(avail), 1);
        do_read();
        chk("read_clears_avail", int'(avail), 0);
        chk("read_keeps_data", int'(data), 8'hB4);
        idle(10);

        // 3: stray pulse 10 ticks before the preamble
        frames = '{22, 0, 0, 0, 0, 16, 24, 8, 0};
        expect_pkt(0, 8'hB4, 0);
        send(0);
        idle(10);
        do_read();
        idle(10);

        // 4: third data frame empty -> single err, then 0x1E
        frames = '{0, 0, 0, 0, 16, 24, -1};
        send(0);
        idle(2);
        chk("err_not_early", int'(err), 0);
        idle(1);
        chk("err_strobe", int'(err), 1);
        idle(1);
        chk("err_single_cycle", int'(err), 0);
        chk("err_no_avail", int'(avail), 0);
        idle(40);
        frames = '{0, 0, 0, 0, 0, 8, 24, 16};
        expect_pkt(0, 8'h1E, 0);
        send(0);
        idle(10);
        do_read();
        idle(10);

        // 5a: 0xB4 then 0x5A without read -> ovf
        frames = '{0, 0, 0, 0, 16, 24, 8, 0};
        expect_pkt(0, 8'hB4, 0);
        send(0);
        idle(10);
        frames = '{0, 0, 0, 0, 8, 8, 16, 16};
        expect_pkt(0, 8'h5A, 1);
        send(0);
        idle(10);
        chk("ovf_data", int'(data), 8'h5A);
        do_read();
        idle(10);

        // 5b: read in the commit cycle -> no ovf, avail stays
        frames = '{0, 0, 0, 0, 16, 24, 8, 0};
        expect_pkt(0, 8'hB4, 0);
        send(0);
        idle(10);
        frames = '{0, 0, 0, 0, 8, 8, 16, 16};
        expect_pkt(0, 8'h5A, 0);
        send(0);
        idle(2);
        read = 1'b1;
        idle(1);
        read = 1'b0;
        chk("read_commit_avail", int'(avail), 1);
        chk("read_commit_ovf", int'(ovf), 0);
        chk("read_commit_data", int'(data), 8'h5A);
        do_read();
        idle(10);

        // 6: 7-bit packet 0x55 sent with pad bit set (symbols 3,1,1,1)
        frames = '{0, 0, 0, 0, 24, 8, 8, 8};
        expect_pkt(1, 7'h55, 0);
        send(1);
        idle(10);
        chk("pad_data", int'(data2), 7'h55);
        // reset in the middle of DATA
        frames = '{0, 0, 0, 0, 16, 24};
        send(1);
        idle(3);
        rst2_n = 1'b0;
        idle(2);
        chk("midreset_data", int'(data2), 0);
        chk("midreset_avail", int'(avail2), 0);
        chk("midreset_err", int'(err2), 0);
        chk("midreset_ovf", int'(ovf2), 0);
        rst2_n = 1'b1;
        idle(100);
        chk("midreset_no_commit", int'(avail2), 0);

        // totals
        chk("err_count", err_seen, 1);
        chk("ovf_count", ovf_seen, 1);
        chk("err7_count", err2_seen, 0);
        chk("ovf7_count", ovf2_seen, 0);
        chk("pending_expected", exp_q.size(), 0);
        chk("pending7_expected", exp2_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
